// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter.
// Holds state encodings, frame width and the default DAC command.
package dac_spi_tx_pkg;

    localparam int FRAME_W = 16;
    localparam logic [3:0] CMD_DEFAULT = 4'h3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] mk_frame(
        input logic [3:0] cmd,
        input logic [7:0] code
    );
        return {cmd, code, 4'b0000};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Request/status and SPI pin bundle of the DAC transmitter.
interface dac_spi_tx_if;

    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [7:0] drop_cnt;
    logic       sclk;
    logic       mosi;
    logic       cs_n;

    modport master (
        output start, data,
        input  busy, done, drop_cnt, sclk, mosi, cs_n
    );

    modport slave (
        input  start, data,
        output busy, done, drop_cnt, sclk, mosi, cs_n
    );

endinterface

// File: rtl/dac_spi_tx_clk_gen.sv
// SCLK divider: CLK_DIV cycles per half-period, idle low when disabled.
// rise/fall flag the cycle at whose end sclk toggles.
module dac_spi_tx_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) sclk <= !sclk;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master for the diode-bias DAC: 16-bit {CMD,code,0000} frames,
// mode 0, with a one-deep pending slot where the newest code wins.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter int         CS_SETUP = 2,
    parameter int         CS_HOLD  = 2,
    parameter int         CS_GAP   = 4,
    parameter logic [3:0] CMD      = CMD_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    dac_spi_tx_if.slave bus
);

    localparam int PMAX = max3(CS_SETUP, CS_HOLD, CS_GAP);
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    state_t             state, state_n;
    logic [PW-1:0]      pcnt, pcnt_n;
    logic [3:0]         bidx, bidx_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic               pend_vld, pend_vld_n;
    logic [7:0]         pend, pend_n;
    logic [7:0]         drops, drops_n;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sclk, rise, fall;
    logic               ph_last, launch;

    dac_spi_tx_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk  (clk),
        .reset(reset),
        .en   (state == S_SHIFT),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

    assign ph_last =
        (state == S_SETUP && pcnt == PW'(CS_SETUP - 1)) ||
        (state == S_HOLD  && pcnt == PW'(CS_HOLD - 1))  ||
        (state == S_GAP   && pcnt == PW'(CS_GAP - 1));

    // GAP exit launches either the incoming code or the pending one
    assign launch =
        (state == S_IDLE && bus.start) ||
        (state == S_GAP && ph_last && (bus.start || pend_vld));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pcnt     <= '0;
            bidx     <= '0;
            shreg    <= '0;
            pend_vld <= 1'b0;
            pend     <= '0;
            drops    <= '0;
            cs_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            bidx     <= bidx_n;
            shreg    <= shreg_n;
            pend_vld <= pend_vld_n;
            pend     <= pend_n;
            drops    <= drops_n;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // bidx counts rises and wraps to 0 on the 16th, so fall at 0 ends bit0
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_n = S_SETUP;
            S_SETUP: if (ph_last) state_n = S_SHIFT;
            S_SHIFT: if (fall && bidx == 4'd0) state_n = S_HOLD;
            S_HOLD:  if (ph_last) state_n = S_GAP;
            S_GAP:   if (ph_last) state_n = launch ? S_SETUP : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pcnt_n     = (state_n == state) ? pcnt + 1'b1 : '0;
        bidx_n     = (state == S_SHIFT) ? bidx + {3'd0, rise} : 4'd0;
        shreg_n    = shreg;
        cs_d       = cs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pend_vld_n = pend_vld;
        pend_n     = pend;
        drops_n    = drops;
        if (launch) begin
            shreg_n = mk_frame(CMD, bus.start ? bus.data : pend);
            cs_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (fall) begin
            shreg_n = {shreg[FRAME_W-2:0], 1'b0};
        end else if (state == S_HOLD && ph_last) begin
            cs_d   = 1'b1;
            done_d = 1'b1;
        end else if (state == S_GAP && ph_last) begin
            busy_d = 1'b0;
        end
        if (launch) begin
            pend_vld_n = 1'b0;
        end else if (bus.start) begin
            pend_vld_n = 1'b1;
            pend_n     = bus.data;
        end
        if (bus.start && state != S_IDLE && pend_vld && drops != 8'hFF)
            drops_n = drops + 8'd1;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.drop_cnt = drops;
    assign bus.sclk     = sclk;
    assign bus.mosi     = shreg[FRAME_W-1];
    assign bus.cs_n     = cs_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: CLK_DIV=4 and CLK_DIV=1 instances.
module tb_dac_spi_tx;

    typedef struct {
        bit          inst;
        logic [15:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [7:0] req_data = 8'h00;
    bit         sel = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t expq[$];
    exp_t mon_e;

    dac_spi_tx_if bus_a ();
    dac_spi_tx_if bus_b ();

    assign bus_a.start = req && !sel;
    assign bus_a.data  = req_data;
    assign bus_b.start = req && sel;
    assign bus_b.data  = req_data;

    dac_spi_tx #(.CLK_DIV(4)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    dac_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    logic [1:0] cs_v, sclk_v, mosi_v, done_v, busy_v;
    assign cs_v   = {bus_b.cs_n, bus_a.cs_n};
    assign sclk_v = {bus_b.sclk, bus_a.sclk};
    assign mosi_v = {bus_b.mosi, bus_a.mosi};
    assign done_v = {bus_b.done, bus_a.done};
    assign busy_v = {bus_b.busy, bus_a.busy};

    function automatic int drop_of(input bit s);
        return s ? int'(bus_b.drop_cnt) : int'(bus_a.drop_cnt);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input bit s, input logic [15:0] f);
        expq.push_back('{inst: s, frame: f});
    endfunction

    // Monitor: rebuilds frames from the SPI pins of both instances
    int          in_fr[2], bits[2], low[2], hi[2], had_end[2];
    int          last_gap[2], frames[2];
    logic [15:0] shr[2];
    logic        prev_cs[2], prev_sclk[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                in_fr[i]   = 0;
                had_end[i] = 0;
            end else begin
                if (!cs_v[i] && prev_cs[i]) begin
                    if (had_end[i] != 0) last_gap[i] = hi[i];
                    in_fr[i] = 1;
                    low[i]   = 0;
                    bits[i]  = 0;
                    shr[i]   = '0;
                end
                if (!cs_v[i] && in_fr[i] != 0) low[i]++;
                if (cs_v[i]) hi[i]++;
                if (sclk_v[i] && !prev_sclk[i] && in_fr[i] != 0) begin
                    shr[i] = {shr[i][14:0], mosi_v[i]};
                    bits[i]++;
                end
                if (cs_v[i] && !prev_cs[i] && in_fr[i] != 0) begin
                    chk($sformatf("done_at_end[%0d]", i), done_v[i], 1);
                    chk($sformatf("bits[%0d]", i), bits[i], 16);
                    chk($sformatf("cs_low_len[%0d]", i), low[i],
                        (i == 1) ? 36 : 132);
                    if (expq.size() == 0) begin
                        chk($sformatf("frame_unexpected[%0d]", i),
                            shr[i], 32'hFFFF_FFFF);
                    end else begin
                        mon_e = expq.pop_front();
                        chk($sformatf("frame_inst[%0d]", i), mon_e.inst, i);
                        chk($sformatf("frame[%0d]", i), shr[i], mon_e.frame);
                    end
                    in_fr[i]   = 0;
                    had_end[i] = 1;
                    hi[i]      = 1;
                    frames[i]++;
                end else if (done_v[i]) begin
                    chk($sformatf("spurious_done[%0d]", i), done_v[i], 0);
                end
            end
            prev_cs[i]   = cs_v[i];
            prev_sclk[i] = sclk_v[i];
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        req      = 1'b1;
        req_data = d;
        tick();
        req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input bit s, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!busy_v[s]) break;
            tick();
        end
        chk("idle_timeout", busy_v[s], 0);
    endtask

    task automatic suite(input bit s);
        int   mid, exitc, f0, edges;
        logic last;
        mid   = s ? 10 : 40;
        exitc = s ? 40 : 136;
        sel   = s;

        do_reset(3);
        chk("rst_cs_n", cs_v[s], 1);
        chk("rst_sclk", sclk_v[s], 0);
        chk("rst_mosi", mosi_v[s], 0);
        chk("rst_busy", busy_v[s], 0);
        chk("rst_done", done_v[s], 0);
        chk("rst_drop", drop_of(s), 0);

        f0 = frames[s];
        push(s, 16'h35A0);
        send(8'h5A);
        chk("t1_cs_low", cs_v[s], 0);
        chk("t1_busy", busy_v[s], 1);
        chk("t1_mosi_b15", mosi_v[s], 0);
        wait_idle(s, 400);
        chk("t1_frames", frames[s] - f0, 1);
        chk("t1_drop", drop_of(s), 0);

        f0 = frames[s];
        push(s, 16'h3100);
        push(s, 16'h3110);
        send(8'h10);
        tick(mid - 1);
        send(8'h11);
        wait_idle(s, 800);
        chk("t2_frames", frames[s] - f0, 2);
        chk("t2_gap", last_gap[s], 4);

        push(s, 16'h3200);
        push(s, 16'h3220);
        send(8'h20);
        tick(10);
        send(8'h21);
        tick(5);
        send(8'h22);
        wait_idle(s, 800);
        chk("t3_drop", drop_of(s), 1);

        if (!s) begin
            push(s, 16'h3500);
            repeat (3) push(s, 16'h3770);
            send(8'h50);
            repeat (300) send(8'h77);
            wait_idle(s, 1500);
            chk("t4_drop_sat", drop_of(s), 255);
        end

        send(8'hAB);
        send(8'hCC);
        last  = sclk_v[s];
        edges = 0;
        for (int k = 0; k < 400 && edges < 7; k++) begin
            tick();
            if (sclk_v[s] != last) edges++;
            last = sclk_v[s];
        end
        chk("t5_edges", edges, 7);
        do_reset(1);
        chk("t5_cs_n", cs_v[s], 1);
        chk("t5_sclk", sclk_v[s], 0);
        chk("t5_busy", busy_v[s], 0);
        chk("t5_drop", drop_of(s), 0);
        tick(3);
        chk("t5_idle", busy_v[s], 0);
        f0 = frames[s];
        push(s, 16'h3FF0);
        send(8'hFF);
        wait_idle(s, 400);
        chk("t5_frames", frames[s] - f0, 1);

        push(s, 16'h32A0);
        push(s, 16'h3310);
        send(8'h2A);
        tick(9);
        send(8'h30);
        tick(exitc - 11);
        send(8'h31);
        wait_idle(s, 800);
        chk("t6_drop", drop_of(s), 1);
        chk("t6_gap", last_gap[s], 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        suite(1'b0);
        suite(1'b1);
        tick(5);
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
